// File: rtl/control_unit_if.sv
// Bus between an instruction source and the RV32I main decoder.
// Handshake: valid_in qualifies opcode on the cycle it is sampled. There is
// no ready, so the decoder accepts one opcode on every rising edge, and the
// control outputs for that opcode appear after the same edge.
interface control_unit_if;
  logic       valid_in;
  logic [6:0] opcode;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       ALUsrc;
  logic       ALUAsrc;
  logic       branch;
  logic       jump;
  logic       jalr;
  logic [1:0] ALUop;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSel;
  logic       illegal;

  modport master (
    output valid_in, opcode,
    input  RegWrite, MemRead, MemWrite, ALUsrc, ALUAsrc, branch, jump, jalr,
    input  ALUop, ResultSrc, ImmSel, illegal
  );

  modport slave (
    input  valid_in, opcode,
    output RegWrite, MemRead, MemWrite, ALUsrc, ALUAsrc, branch, jump, jalr,
    output ALUop, ResultSrc, ImmSel, illegal
  );
endinterface

// File: rtl/control_unit.sv
// RV32I main control decoder. The opcode is decoded combinationally and the
// full control word is registered, giving one cycle of latency and
// glitch-free outputs. The only state is the output register.
module control_unit (
  input  logic          clk,
  input  logic          rst_n,
  control_unit_if.slave bus
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       alu_a_src;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [2:0] imm_sel;
    logic       illegal;
  } ctrl_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  // Decode the opcode into a control word; a bubble yields all zeros.
  always_comb begin
    ctrl_d = '0;
    if (bus.valid_in) begin
      case (bus.opcode)
        OP_R: begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_op    = 2'b10;
        end
        OP_I: begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.alu_op    = 2'b11;
        end
        OP_LOAD: begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.mem_read   = 1'b1;
          ctrl_d.alu_src    = 1'b1;
          ctrl_d.result_src = 2'b01;
        end
        OP_JALR: begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.alu_src    = 1'b1;
          ctrl_d.jump       = 1'b1;
          ctrl_d.jalr       = 1'b1;
          ctrl_d.result_src = 2'b10;
        end
        OP_STORE: begin
          ctrl_d.mem_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.imm_sel   = 3'b001;
        end
        OP_BR: begin
          ctrl_d.branch  = 1'b1;
          ctrl_d.alu_op  = 2'b01;
          ctrl_d.imm_sel = 3'b010;
        end
        OP_LUI: begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.alu_src    = 1'b1;
          ctrl_d.result_src = 2'b11;
          ctrl_d.imm_sel    = 3'b011;
        end
        OP_AUIPC: begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.alu_a_src = 1'b1;
          ctrl_d.imm_sel   = 3'b011;
        end
        OP_JAL: begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.jump       = 1'b1;
          ctrl_d.result_src = 2'b10;
          ctrl_d.imm_sel    = 3'b100;
        end
        default: ctrl_d.illegal = 1'b1;
      endcase
    end
  end

  // Register the control word; reset clears it without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign bus.RegWrite  = ctrl_q.reg_write;
  assign bus.MemRead   = ctrl_q.mem_read;
  assign bus.MemWrite  = ctrl_q.mem_write;
  assign bus.ALUsrc    = ctrl_q.alu_src;
  assign bus.ALUAsrc   = ctrl_q.alu_a_src;
  assign bus.branch    = ctrl_q.branch;
  assign bus.jump      = ctrl_q.jump;
  assign bus.jalr      = ctrl_q.jalr;
  assign bus.ALUop     = ctrl_q.alu_op;
  assign bus.ResultSrc = ctrl_q.result_src;
  assign bus.ImmSel    = ctrl_q.imm_sel;
  assign bus.illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Bench for the RV32I main control decoder. Inputs change on the falling
// edge; outputs are checked 1 ns after the rising edge that decoded them.
// Control word packing: {RegWrite,MemRead,MemWrite,ALUsrc,ALUAsrc,branch,
// jump,jalr,ALUop[1:0],ResultSrc[1:0],ImmSel[2:0],illegal}.
module tb_control_unit;

  logic clk;
  logic rst_n;
  control_unit_if bus ();

  control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [15:0] exp_q[$];

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.opcode   = 7'b0;
  end

  // Reference table written directly from the decode rows.
  function automatic logic [15:0] model(input logic v, input logic [6:0] op);
    if (!v) return 16'h0000;
    case (op)
      7'b0110011: return {8'b1000_0000, 2'b10, 2'b00, 3'b000, 1'b0};
      7'b0010011: return {8'b1001_0000, 2'b11, 2'b00, 3'b000, 1'b0};
      7'b0000011: return {8'b1101_0000, 2'b00, 2'b01, 3'b000, 1'b0};
      7'b1100111: return {8'b1001_0011, 2'b00, 2'b10, 3'b000, 1'b0};
      7'b0100011: return {8'b0011_0000, 2'b00, 2'b00, 3'b001, 1'b0};
      7'b1100011: return {8'b0000_0100, 2'b01, 2'b00, 3'b010, 1'b0};
      7'b0110111: return {8'b1001_0000, 2'b00, 2'b11, 3'b011, 1'b0};
      7'b0010111: return {8'b1001_1000, 2'b00, 2'b00, 3'b011, 1'b0};
      7'b1101111: return {8'b1000_0010, 2'b00, 2'b10, 3'b100, 1'b0};
      default:    return {15'b0, 1'b1};
    endcase
  endfunction

  function automatic logic [15:0] observed();
    return {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.ALUsrc, bus.ALUAsrc,
            bus.branch, bus.jump, bus.jalr, bus.ALUop, bus.ResultSrc,
            bus.ImmSel, bus.illegal};
  endfunction

  // Driver: present one opcode at the falling edge and record its expectation.
  task automatic drive_op(input logic v, input logic [6:0] op);
    @(negedge clk);
    bus.valid_in = v;
    bus.opcode   = op;
    exp_q.push_back(model(v, op));
  endtask

  task automatic test_reset();
    logic [15:0] got;
    #3;
    got = observed();
    tests_run++;
    if (got !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_async got=%h exp=0000", got);
    end
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.opcode   = 7'b0000011;
    @(posedge clk); #1;
    got = observed();
    tests_run++;
    if (got !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_held got=%h exp=0000", got);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_all_rows();
    logic [6:0] ops [9];
    logic [15:0] got, exp;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    for (int i = 0; i < 9; i++) begin
      drive_op(1'b1, ops[i]);
      @(posedge clk); #1;
      got = observed();
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL row_%b got=%h exp=%h", ops[i], got, exp);
      end
    end
  endtask

  task automatic test_illegal_and_bubble();
    logic [15:0] got, exp;
    drive_op(1'b1, 7'b0000000);
    @(posedge clk); #1;
    got = observed(); exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp || got !== 16'h0001) begin
      tests_failed++;
      $display("FAIL illegal_zero got=%h exp=%h", got, exp);
    end
    drive_op(1'b1, 7'b0110000);
    @(posedge clk); #1;
    got = observed(); exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL illegal_lowbits got=%h exp=%h", got, exp);
    end
    drive_op(1'b0, 7'b0000011);
    @(posedge clk); #1;
    got = observed(); exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp || bus.MemRead !== 1'b0 || bus.illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL bubble got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] got, exp;
    drive_op(1'b1, 7'b0000011);
    @(posedge clk); #1;
    got = observed(); exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL load_before_reset got=%h exp=%h", got, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    got = observed();
    tests_run++;
    if (got !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_no_clock got=%h exp=0000", got);
    end
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.opcode   = 7'b0100011;
    @(posedge clk); #1;
    got = observed();
    tests_run++;
    if (got !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_discard got=%h exp=0000", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(1'b1, 7'b0100011));
    @(posedge clk); #1;
    got = observed(); exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL first_after_release got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_store_load_toggle();
    logic [15:0] got, exp;
    for (int i = 0; i < 6; i++) begin
      drive_op(1'b1, (i % 2 == 0) ? 7'b0100011 : 7'b0000011);
      @(posedge clk); #1;
      got = observed(); exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp || (bus.MemRead & bus.MemWrite) ||
          bus.MemWrite !== (i % 2 == 0)) begin
        tests_failed++;
        $display("FAIL store_load_%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_jumps();
    logic [15:0] got, exp;
    drive_op(1'b1, 7'b1100111);
    @(posedge clk); #1;
    got = observed(); exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp || bus.jump !== 1'b1 || bus.jalr !== 1'b1 ||
        bus.ResultSrc !== 2'b10 || bus.ImmSel !== 3'b000) begin
      tests_failed++;
      $display("FAIL jalr got=%h exp=%h", got, exp);
    end
    drive_op(1'b1, 7'b1101111);
    @(posedge clk); #1;
    got = observed(); exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp || bus.jump !== 1'b1 || bus.jalr !== 1'b0 ||
        bus.ResultSrc !== 2'b10 || bus.ImmSel !== 3'b100) begin
      tests_failed++;
      $display("FAIL jal got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] legal [9];
    logic [6:0] op;
    logic v;
    logic [15:0] got, exp;
    legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    for (int i = 0; i < 40; i++) begin
      v  = ($urandom_range(0, 4) != 0);
      op = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 8)]
                                       : 7'($urandom_range(0, 127));
      drive_op(v, op);
      @(posedge clk); #1;
      got = observed();
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL b2b_queue_empty got=%h exp=none", got);
      end else begin
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp || (bus.MemRead & bus.MemWrite) ||
            (bus.RegWrite & (bus.MemWrite | bus.branch)) ||
            (bus.jalr & ~bus.jump)) begin
          tests_failed++;
          $display("FAIL b2b_%0d v=%b op=%b got=%h exp=%h", i, v, op, got, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_rows();
    test_illegal_and_bubble();
    test_mid_reset();
    test_store_load_toggle();
    test_jumps();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 valid_in  input  1  opcode qualifier; 1 = opcode holds a real instruction.
REQ-005 opcode  input  7  RV32I major opcode, instr[6:0].
REQ-006 RegWrite  output  1  write register file rd.
REQ-007 MemRead  output  1  data-memory read (loads).
REQ-008 MemWrite  output  1  data-memory write (stores).
REQ-009 ALUsrc  output  1  ALU operand B: 0 = rs2, 1 = immediate.
REQ-010 ALUAsrc  output  1  ALU operand A: 0 = rs1, 1 = PC.
REQ-011 branch  output  1  conditional branch instruction.
REQ-012 jump  output  1  unconditional jump (JAL or JALR).
REQ-013 jalr  output  1  jump target from rs1 + imm (JALR only).
REQ-014 ALUop  output  2  00 add, 01 branch compare, 10 R-type funct decode, 11 I-type funct decode.
REQ-015 ResultSrc  output  2  writeback select: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
REQ-016 ImmSel  output  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J.
REQ-017 illegal  output  1  valid_in high with an unsupported opcode.

Function
REQ-018 All outputs registered; decode of opcode/valid_in sampled at rising edge N appears at outputs after edge N (1-cycle latency), held until next edge.
REQ-019 Unlisted control bits are 0 for each row.
REQ-020 0110011 R: RegWrite=1, ALUsrc=0, ALUop=10, ResultSrc=00, ImmSel=000.
REQ-021 0010011 I-ALU: RegWrite=1, ALUsrc=1, ALUop=11, ResultSrc=00, ImmSel=000.
REQ-022 0000011 Load: RegWrite=1, MemRead=1, ALUsrc=1, ALUop=00, ResultSrc=01, ImmSel=000.
REQ-023 1100111 JALR: RegWrite=1, ALUsrc=1, jump=1, jalr=1, ALUop=00, ResultSrc=10, ImmSel=000.
REQ-024 0100011 Store: MemWrite=1, ALUsrc=1, ALUop=00, ImmSel=001.
REQ-025 1100011 Branch: branch=1, ALUsrc=0, ALUop=01, ImmSel=010.
REQ-026 0110111 LUI: RegWrite=1, ALUsrc=1, ALUop=00, ResultSrc=11, ImmSel=011.
REQ-027 0010111 AUIPC: RegWrite=1, ALUsrc=1, ALUAsrc=1, ALUop=00, ResultSrc=00, ImmSel=011.
REQ-028 1101111 JAL: RegWrite=1, jump=1, ALUop=00, ResultSrc=10, ImmSel=100.
REQ-029 Any other opcode (incl. 0000000 and opcode[1:0]!=11) with valid_in=1: all controls 0, illegal=1.
REQ-030 valid_in=0: all outputs 0 including illegal (bubble), regardless of opcode.
REQ-031 MemRead and MemWrite never both 1; RegWrite never 1 with MemWrite or branch; jalr=1 implies jump=1.
REQ-032 Back-to-back opcodes decoded every cycle with no stall; no internal state beyond output registers.

Reset
REQ-033 rst_n low asynchronously forces every output to 0 immediately, independent of clk.
REQ-034 While rst_n low outputs stay 0; first decode after release occurs on first rising edge with rst_n high.
REQ-035 Reset asserted mid-stream discards the pending decode; no output glitches to a non-zero value during reset.

Verification
REQ-036 Reset, then valid_in=1 and opcodes 0110011, 0010011, 0000011, 1100111, 0100011, 1100011, 0110111, 0010111, 1101111 one per cycle -> each row of REQ-020..028 appears one cycle after its opcode.
REQ-037 valid_in=1, opcode=0000000 -> next cycle illegal=1, all other outputs 0.
REQ-038 valid_in=0, opcode=0000011 -> next cycle all outputs 0, MemRead=0, illegal=0.
REQ-039 Load decoded (RegWrite=1, MemRead=1), then rst_n low between edges -> outputs 0 immediately without a clock edge.
REQ-040 Alternate store/load each cycle -> MemWrite and MemRead toggle complementary, never both 1.
REQ-041 opcode=1100111 then 1101111 -> jump=1 both cycles, jalr=1 then 0, ResultSrc=10 both, ImmSel 000 then 100.
